// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock set controller: state encodings,
// per-field blink masks, mode LED codes and small decode helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ADJ_HOUR = 2'd1,
        ST_ADJ_MIN  = 2'd2
    } state_t;

    localparam logic [3:0] HOUR_MASK = 4'b1100;
    localparam logic [3:0] MIN_MASK  = 4'b0011;
    localparam logic [3:0] NO_MASK   = 4'b0000;

    localparam logic [1:0] LED_RUN      = 2'b00;
    localparam logic [1:0] LED_ADJ_HOUR = 2'b01;
    localparam logic [1:0] LED_ADJ_MIN  = 2'b10;

    // Digits that flash while a state is active.
    function automatic logic [3:0] field_mask(input state_t st);
        logic [3:0] mask;
        case (st)
            ST_ADJ_HOUR: mask = HOUR_MASK;
            ST_ADJ_MIN:  mask = MIN_MASK;
            default:     mask = NO_MASK;
        endcase
        return mask;
    endfunction

    // Front-panel LED code for a state.
    function automatic logic [1:0] mode_code(input state_t st);
        logic [1:0] code;
        case (st)
            ST_ADJ_HOUR: code = LED_ADJ_HOUR;
            ST_ADJ_MIN:  code = LED_ADJ_MIN;
            default:     code = LED_RUN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink half-period generator: counts 0..BLINK_HALF-1 while enabled and
// toggles phase on each wrap. A synchronous clear restarts it with the
// digits visible (phase 0). wrap flags the cycle on which phase will toggle,
// so the parent can register the upcoming phase into its outputs.
module blink_gen #(
    parameter int BLINK_HALF = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic phase,
    output logic wrap
);

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             phase_r;
    logic             phase_s;
    logic             wrap_s;

    // Next counter/phase: clear dominates, then count while enabled.
    always_comb begin
        cnt_s   = cnt_r;
        phase_s = phase_r;
        wrap_s  = 1'b0;
        if (clr) begin
            cnt_s   = {CNT_W{1'b0}};
            phase_s = 1'b0;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_s   = {CNT_W{1'b0}};
                phase_s = ~phase_r;
                wrap_s  = 1'b1;
            end else begin
                cnt_s   = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s   = cnt_r;
            phase_s = phase_r;
        end
    end

    // Counter and phase registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
        end
    end

    assign phase = phase_r;
    assign wrap  = wrap_s;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode controller for the digital clock: RUN / adjust-hours / adjust-minutes.
// Converts button pulses into adjust strobes, drives the timer run enable,
// the seconds clear pulse, the mode LEDs and the blink mask of the field
// being adjusted. An idle timeout returns to RUN after TIMEOUT_S seconds.
// All outputs are registered from the next-state values, so they change on
// the same edge as the state register.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_HALF = 50_000_000,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       run_en,
    output logic       sec_clear,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic [3:0] digit_blank,
    output logic [1:0] mode_led
);

    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S);

    state_t            state_r;
    state_t            state_s;
    logic [IDLE_W-1:0] idle_r;
    logic [IDLE_W-1:0] idle_s;

    logic       any_btn_s;
    logic       timeout_s;
    logic       sec_clear_s;
    logic       hour_inc_s;
    logic       hour_dec_s;
    logic       min_inc_s;
    logic       min_dec_s;
    logic       strobe_s;
    logic       enter_adj_s;
    logic       blink_clr_s;
    logic       blink_en_s;
    logic       phase_s;
    logic       wrap_s;
    logic       phase_next_s;
    logic [3:0] blank_s;

    logic       run_en_r;
    logic       sec_clear_r;
    logic       hour_inc_r;
    logic       hour_dec_r;
    logic       min_inc_r;
    logic       min_dec_r;
    logic [3:0] digit_blank_r;
    logic [1:0] mode_led_r;

    // Idle timeout fires on the terminal tick unless a button arrives with it.
    always_comb begin
        any_btn_s = btn_mode | btn_up | btn_down;
        if ((state_r != ST_RUN) && tick_1hz && !any_btn_s &&
            ((idle_r + IDLE_W'(1)) == IDLE_LAST)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state and strobe decode; btn_mode beats both timeout and adjust.
    always_comb begin
        state_s     = state_r;
        sec_clear_s = 1'b0;
        hour_inc_s  = 1'b0;
        hour_dec_s  = 1'b0;
        min_inc_s   = 1'b0;
        min_dec_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (btn_mode) begin
                    state_s = ST_ADJ_HOUR;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ADJ_HOUR: begin
                if (btn_mode) begin
                    state_s = ST_ADJ_MIN;
                end else if (timeout_s) begin
                    state_s     = ST_RUN;
                    sec_clear_s = 1'b1;
                end else begin
                    hour_inc_s = btn_up & ~btn_down;
                    hour_dec_s = btn_down & ~btn_up;
                end
            end
            ST_ADJ_MIN: begin
                if (btn_mode) begin
                    state_s     = ST_RUN;
                    sec_clear_s = 1'b1;
                end else if (timeout_s) begin
                    state_s     = ST_RUN;
                    sec_clear_s = 1'b1;
                end else begin
                    min_inc_s = btn_up & ~btn_down;
                    min_dec_s = btn_down & ~btn_up;
                end
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase
    end

    // Idle counter next value: restarts on any button, state change or RUN.
    always_comb begin
        if ((state_s != state_r) || any_btn_s || (state_s == ST_RUN)) begin
            idle_s = {IDLE_W{1'b0}};
        end else if (tick_1hz) begin
            idle_s = idle_r + IDLE_W'(1);
        end else begin
            idle_s = idle_r;
        end
    end

    // Blink control and the mask that will be visible after this edge.
    always_comb begin
        strobe_s     = hour_inc_s | hour_dec_s | min_inc_s | min_dec_s;
        enter_adj_s  = (state_s != state_r) && (state_s != ST_RUN);
        blink_en_s   = (state_s != ST_RUN);
        blink_clr_s  = enter_adj_s | strobe_s | (state_s == ST_RUN);
        if (blink_clr_s) begin
            phase_next_s = 1'b0;
        end else begin
            phase_next_s = phase_s ^ wrap_s;
        end
        if (phase_next_s) begin
            blank_s = field_mask(state_s);
        end else begin
            blank_s = NO_MASK;
        end
    end

    blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .clk   (clk),
        .reset (reset),
        .clr   (blink_clr_s),
        .en    (blink_en_s),
        .phase (phase_s),
        .wrap  (wrap_s)
    );

    // State and idle counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_RUN;
            idle_r  <= {IDLE_W{1'b0}};
        end else begin
            state_r <= state_s;
            idle_r  <= idle_s;
        end
    end

    // Output registers, loaded from the next-state decode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_en_r      <= 1'b1;
            sec_clear_r   <= 1'b0;
            hour_inc_r    <= 1'b0;
            hour_dec_r    <= 1'b0;
            min_inc_r     <= 1'b0;
            min_dec_r     <= 1'b0;
            digit_blank_r <= NO_MASK;
            mode_led_r    <= LED_RUN;
        end else begin
            run_en_r      <= (state_s == ST_RUN);
            sec_clear_r   <= sec_clear_s;
            hour_inc_r    <= hour_inc_s;
            hour_dec_r    <= hour_dec_s;
            min_inc_r     <= min_inc_s;
            min_dec_r     <= min_dec_s;
            digit_blank_r <= blank_s;
            mode_led_r    <= mode_code(state_s);
        end
    end

    assign run_en      = run_en_r;
    assign sec_clear   = sec_clear_r;
    assign hour_inc    = hour_inc_r;
    assign hour_dec    = hour_dec_r;
    assign min_inc     = min_inc_r;
    assign min_dec     = min_dec_r;
    assign digit_blank = digit_blank_r;
    assign mode_led    = mode_led_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short blink and timeout periods.
// Each cycle's expected outputs come from a cycle model and go through a
// scoreboard queue; spot checks against fixed constants back up the model.
module tb_clock_set_ctrl;

    localparam int BH = 4;
    localparam int TO = 3;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       run_en;
    logic       sec_clear;
    logic       hour_inc;
    logic       hour_dec;
    logic       min_inc;
    logic       min_dec;
    logic [3:0] digit_blank;
    logic [1:0] mode_led;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    logic [11:0] exp_q[$];

    // model state: 0 run, 1 adjust hours, 2 adjust minutes
    int m_state = 0;
    int m_cnt   = 0;
    int m_phase = 0;
    int m_idle  = 0;

    clock_set_ctrl #(
        .BLINK_HALF (BH),
        .TIMEOUT_S  (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .run_en      (run_en),
        .sec_clear   (sec_clear),
        .hour_inc    (hour_inc),
        .hour_dec    (hour_dec),
        .min_inc     (min_inc),
        .min_dec     (min_dec),
        .digit_blank (digit_blank),
        .mode_led    (mode_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after the coming edge for the given inputs.
    task automatic model_step(input logic r, m, u, d, t, output logic [11:0] e);
        int  ns;
        bit  hi, hd, mi, md, sc, tmo, any, strobe, entering;
        logic [3:0] blank;
        if (!r) begin
            m_state = 0; m_cnt = 0; m_phase = 0; m_idle = 0;
            e = {1'b1, 5'b00000, 4'b0000, 2'b00};
        end else begin
            any = m | u | d;
            hi  = (m_state == 1) && !m && u && !d;
            hd  = (m_state == 1) && !m && d && !u;
            mi  = (m_state == 2) && !m && u && !d;
            md  = (m_state == 2) && !m && d && !u;
            tmo = (m_state != 0) && !any && t && (m_idle + 1 == TO);
            if (m) ns = (m_state + 1) % 3;
            else if (tmo) ns = 0;
            else ns = m_state;
            sc = ((m_state == 2) && m) || tmo;
            entering = (ns != m_state) && (ns != 0);
            strobe = hi | hd | mi | md;
            if (ns == 0 || entering || strobe) begin
                m_cnt = 0; m_phase = 0;
            end else if (m_cnt == BH - 1) begin
                m_cnt = 0; m_phase = 1 - m_phase;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (ns != m_state || any || ns == 0) m_idle = 0;
            else if (t) m_idle = m_idle + 1;
            m_state = ns;
            if (ns != 0 && m_phase == 1) blank = (ns == 1) ? 4'b1100 : 4'b0011;
            else blank = 4'b0000;
            e = {(ns == 0), sc, hi, hd, mi, md, blank, 2'(ns)};
        end
    endtask

    // Drive one cycle of inputs, push expectation, compare after the edge.
    task automatic cyc(input logic r, m, u, d, t);
        logic [11:0] e;
        logic [11:0] got;
        logic [11:0] want;
        @(negedge clk);
        reset = r; btn_mode = m; btn_up = u; btn_down = d; tick_1hz = t;
        model_step(r, m, u, d, t, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        got  = {run_en, sec_clear, hour_inc, hour_dec, min_inc, min_dec, digit_blank, mode_led};
        want = exp_q.pop_front();
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL cycle_%0d outputs: observed %b expected %b", cyc_no, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Spot check of one output against a fixed value.
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;

        // reset and idle run
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_run_en", {3'b000, run_en}, 4'b0001);
        chk("rst_mode_led", {2'b00, mode_led}, 4'b0000);
        chk("rst_blank", digit_blank, 4'b0000);

        // adjust hours: three increments, one decrement
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("hour_mode_led", {2'b00, mode_led}, 4'b0001);
        chk("hour_run_en", {3'b000, run_en}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("hour_inc_on", {3'b000, hour_inc}, 4'b0001);
            chk("hour_no_min", {2'b00, min_inc, min_dec}, 4'b0000);
            idle(1);
            chk("hour_inc_off", {3'b000, hour_inc}, 4'b0000);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hour_dec_on", {3'b000, hour_dec}, 4'b0001);

        // mode with up: mode wins; then up+down together does nothing
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mode_beats_up", {hour_inc, hour_dec, min_inc, min_dec}, 4'b0000);
        chk("min_mode_led", {2'b00, mode_led}, 4'b0010);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("up_down_none", {hour_inc, hour_dec, min_inc, min_dec}, 4'b0000);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("min_inc_on", {3'b000, min_inc}, 4'b0001);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("exit_sec_clear", {3'b000, sec_clear}, 4'b0001);
        chk("exit_run_en", {3'b000, run_en}, 4'b0001);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("run_ignores_up", {sec_clear, hour_inc, min_inc, min_dec}, 4'b0000);

        // blink in adjust minutes
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("blink_visible", digit_blank, 4'b0000);
        idle(1);
        chk("blink_blank", digit_blank, 4'b0011);
        idle(4);
        chk("blink_back", digit_blank, 4'b0000);
        idle(6);
        chk("blink_mid_blank", digit_blank, 4'b0011);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("dec_restart_blank", digit_blank, 4'b0000);
        chk("min_dec_on", {3'b000, min_dec}, 4'b0001);
        idle(3);
        chk("restart_visible", digit_blank, 4'b0000);
        idle(1);
        chk("restart_blank", digit_blank, 4'b0011);

        // reset while blanked in adjust minutes
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_led", {2'b00, mode_led}, 4'b0000);
        chk("midrst_blank", digit_blank, 4'b0000);
        chk("midrst_no_sc", {3'b000, sec_clear}, 4'b0000);
        idle(1);

        // timeout from adjust hours
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); idle(1); tick(); idle(1);
        chk("pre_timeout_led", {2'b00, mode_led}, 4'b0001);
        tick();
        chk("timeout_sc", {3'b000, sec_clear}, 4'b0001);
        chk("timeout_led", {2'b00, mode_led}, 4'b0000);
        idle(1);

        // button on terminal tick cancels timeout
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("cancel_led", {2'b00, mode_led}, 4'b0001);
        chk("cancel_inc", {2'b00, hour_inc, sec_clear}, 4'b0010);
        tick(); tick();
        chk("cancel_still_hour", {2'b00, mode_led}, 4'b0001);
        tick();
        chk("late_timeout_sc", {3'b000, sec_clear}, 4'b0001);

        // tick with mode: transition taken, idle restarts in new state
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tick_mode_led", {2'b00, mode_led}, 4'b0010);
        tick(); tick();
        chk("tick_mode_stay", {2'b00, mode_led}, 4'b0010);
        tick();
        chk("tick_mode_timeout", {2'b00, sec_clear, run_en}, 4'b0011);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode controller for the Basys3 digital clock: decides whether the hour/minute timer runs or is adjusted from the push-buttons. It turns single-cycle button pulses into increment/decrement strobes for the hours and minutes fields and a run-enable for the timer. It also drives a per-digit blink mask to the 7-segment multiplexer so the field being adjusted flashes. It sits between the button edge-detectors and the timer/display datapath.

## Interface
- BLINK_HALF, 50_000_000: clk cycles per blink half-period (0.5 s at 100 MHz).
- TIMEOUT_S, 10: seconds without a button press in an adjust state before returning to run.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle pulse once per second.
- btn_mode  in  1  one-cycle pulse, debounced centre button.
- btn_up  in  1  one-cycle pulse, increment the selected field.
- btn_down  in  1  one-cycle pulse, decrement the selected field.
- run_en  out  1  timer count enable.
- sec_clear  out  1  one-cycle pulse that zeroes the seconds.
- hour_inc, hour_dec  out  1 each  one-cycle adjust strobes for the hours field.
- min_inc, min_dec  out  1 each  one-cycle adjust strobes for the minutes field.
- digit_blank  out  4  1 = blank that digit; [3:2] hours, [1:0] minutes.
- mode_led  out  2  00 run, 01 adjust hours, 10 adjust minutes.

## Operation
- States: RUN, ADJ_HOUR, ADJ_MIN.
- RUN:
  - run_en = 1.
  - btn_mode goes to ADJ_HOUR.
  - btn_up and btn_down are ignored.
- ADJ_HOUR:
  - run_en = 0.
  - btn_mode goes to ADJ_MIN.
  - btn_up produces hour_inc; btn_down produces hour_dec.
- ADJ_MIN:
  - run_en = 0.
  - btn_mode goes to RUN and pulses sec_clear.
  - btn_up produces min_inc; btn_down produces min_dec.
- Simultaneous button events:
  - btn_up and btn_down in the same cycle: no strobe.
  - btn_mode with btn_up or btn_down: btn_mode wins and no adjust strobe is issued.
- Blink:
  - A cycle counter runs only in the ADJ states, counting 0..BLINK_HALF-1; phase toggles on wrap.
  - Counter and phase are cleared (digits visible) on entering any ADJ state and on every adjust strobe.
  - digit_blank = phase ? field mask : 4'b0000. Field mask is 1100 in ADJ_HOUR and 0011 in ADJ_MIN.
  - digit_blank = 0 in RUN.
- Timeout:
  - An idle counter (width clog2(TIMEOUT_S+1)) counts tick_1hz only in the ADJ states.
  - It is cleared on any btn_* pulse and on state entry.
  - When it reaches TIMEOUT_S, go to RUN and pulse sec_clear.
  - A btn_* pulse in the same cycle as the terminal tick takes priority: the counter clears and no timeout occurs.
- This block does no field arithmetic. Wrap (59→0, 23→0, 0→59) is the timer's job.

## Timing
- All outputs are registered.
- Strobes, sec_clear and state-derived outputs change one cycle after the causing pulse.
- Every strobe is exactly one cycle wide; at most one adjust strobe is active per cycle.
- Reset values: state RUN, run_en = 1, all strobes 0, digit_blank = 0000, mode_led = 00, counters 0.
- Reset asserted mid-adjust: back in RUN on the next clk edge, with no sec_clear and no strobe.
- tick_1hz coinciding with btn_mode: the transition is taken and the idle counter restarts at 0 in the new state.

## Structure
- Shared package/header `clock_pkg`:
  - state encodings (RUN = 2'd0, ADJ_HOUR = 2'd1, ADJ_MIN = 2'd2);
  - field masks HOUR_MASK = 4'b1100 and MIN_MASK = 4'b0011;
  - mode_led codes.
- One sub-module, `blink_gen`: the parameterised half-period counter with sync clear and enable, producing phase.
- The FSM, timeout counter and output registers live in clock_set_ctrl.

## Test plan
- Reset low for 2 cycles, then high → run_en = 1, mode_led = 00, digit_blank = 0000, no strobes.
- btn_mode, then btn_up ×3 → mode_led = 01, three hour_inc pulses of 1 cycle each, each one cycle after its btn_up, and no min_* strobes.
- btn_mode ×2, then btn_up and btn_down in the same cycle → state ADJ_MIN with no strobe. Then btn_mode → RUN with one sec_clear pulse and run_en = 1.
- In ADJ_MIN with BLINK_HALF = 4 → digit_blank alternates 0000/0011 every 4 cycles. A btn_down forces 0000 on the next cycle and restarts the count.
- In ADJ_HOUR with TIMEOUT_S = 3, 3 tick_1hz pulses and no buttons → RUN plus sec_clear. Repeat with btn_up on the 3rd tick → stays in ADJ_HOUR.
- Reset low while in ADJ_MIN with phase blanked → next cycle RUN, digit_blank = 0000, no sec_clear.
